// File: rtl/memory_stage_pkg.sv
// Shared encodings for the memory stage: FSM states, address/write-source selects,
// interrupt vector address and the per-operation word count.
package memory_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WORD2 = 2'd1,
        ST_WORD3 = 2'd2
    } state_t;

    localparam logic [1:0] ASEL_ALU    = 2'b00;
    localparam logic [1:0] ASEL_SP     = 2'b01;
    localparam logic [1:0] ASEL_SP_INC = 2'b10;
    localparam logic [1:0] ASEL_VECTOR = 2'b11;

    localparam logic [1:0] WSRC_RD2       = 2'b00;
    localparam logic [1:0] WSRC_PC_NEXT   = 2'b01;
    localparam logic [1:0] WSRC_INTERRUPT = 2'b10;
    localparam logic [1:0] WSRC_RD1       = 2'b11;

    localparam int VECTOR_ADDR = 0;

    localparam logic [1:0] WORDS_1 = 2'd1;
    localparam logic [1:0] WORDS_2 = 2'd2;
    localparam logic [1:0] WORDS_3 = 2'd3;

    // Number of memory words moved by the operation currently held on the EX/MEM inputs.
    function automatic logic [1:0] op_words(
        input logic       push,
        input logic       pop,
        input logic [1:0] wsrc,
        input logic       choose_int,
        input logic       choose_mem
    );
        logic [1:0] n;
        n = WORDS_1;
        if (push) begin
            if (wsrc == WSRC_PC_NEXT)
                n = WORDS_2;
            else if (wsrc == WSRC_INTERRUPT)
                n = WORDS_3;
        end else if (pop) begin
            if (choose_int)
                n = WORDS_3;
            else if (choose_mem)
                n = WORDS_2;
        end
        return n;
    endfunction

endpackage

// File: rtl/memory_stage_stack_pointer.sv
// Stack pointer register: reloadable, steps by one word per cycle in either
// direction and wraps naturally modulo 2^ADDR_W.
module stack_pointer #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_inc,
    input  logic              i_dec,
    output logic [ADDR_W-1:0] o_sp,
    output logic [ADDR_W-1:0] o_sp_up
);

    logic [ADDR_W-1:0] r_sp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_sp <= SP_RESET;
        else if (i_load)
            r_sp <= i_load_val;
        else if (i_inc && !i_dec)
            r_sp <= r_sp + 1'b1;
        else if (i_dec && !i_inc)
            r_sp <= r_sp - 1'b1;
    end

    assign o_sp    = r_sp;
    assign o_sp_up = r_sp + 1'b1;

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: data-memory access, multi-word stack push/pop sequencing
// with upstream stall, PC/flag restore on pop, and the MEM/WB register.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       alu_result,
    input  logic [15:0]       read_data1,
    input  logic [15:0]       read_data2,
    input  logic [15:0]       ldm_value,
    input  logic [31:0]       pc,
    input  logic [31:0]       pc_plus_one,
    input  logic [2:0]        flag_register,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_push,
    input  logic              mem_pop,
    input  logic              reg_write,
    input  logic              pc_choose_interrupt,
    input  logic              pc_choose_memory,
    input  logic [1:0]        memory_address_select,
    input  logic [1:0]        memory_write_src_select,
    input  logic [1:0]        wb_sel,
    input  logic [2:0]        reg_write_address,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [15:0]       dm_wdata,
    output logic              dm_we,
    output logic              dm_re,
    input  logic [15:0]       dm_rdata,
    output logic              stall,
    output logic [31:0]       pc_from_memory,
    output logic              pc_from_memory_valid,
    output logic [2:0]        conditions_from_memory_pop,
    output logic              wb_reg_write,
    output logic [2:0]        wb_reg_write_address,
    output logic [1:0]        wb_sel_out,
    output logic [15:0]       wb_alu_result,
    output logic [15:0]       wb_mem_data,
    output logic [15:0]       wb_ldm_value,
    output logic [ADDR_W-1:0] sp_out
);

    state_t            r_state;
    state_t            w_next_state;
    logic [15:0]       r_pop_lo;
    logic [2:0]        r_pop_flags;

    logic              w_push;
    logic              w_pop;
    logic              w_stack;
    logic [1:0]        w_words;
    logic              w_sp_inc;
    logic              w_sp_dec;
    logic              w_low_word;
    logic              w_flags_word;
    logic              w_pc_pop_done;
    logic [ADDR_W-1:0] w_sp;
    logic [ADDR_W-1:0] w_sp_up;

    // Push and pop together cancel out: no access and no SP movement.
    assign w_push  = mem_push & ~mem_pop;
    assign w_pop   = mem_pop & ~mem_push;
    assign w_stack = mem_push | mem_pop;
    assign w_words = op_words(w_push, w_pop, memory_write_src_select,
                              pc_choose_interrupt, pc_choose_memory);

    stack_pointer #(
        .ADDR_W   (ADDR_W),
        .SP_RESET (SP_RESET)
    ) u_stack_pointer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (1'b0),
        .i_load_val (SP_RESET),
        .i_inc      (w_sp_inc),
        .i_dec      (w_sp_dec),
        .o_sp       (w_sp),
        .o_sp_up    (w_sp_up)
    );

    assign sp_out = w_sp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_words != WORDS_1) w_next_state = ST_WORD2;
            ST_WORD2: w_next_state = (w_words == WORDS_3) ? ST_WORD3 : ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // SP moves one word per cycle, so SP / SP+1 always address the current word.
    always_comb begin
        case (memory_address_select)
            ASEL_ALU:    dm_addr = alu_result[ADDR_W-1:0];
            ASEL_SP:     dm_addr = w_sp;
            ASEL_SP_INC: dm_addr = w_sp_up;
            default:     dm_addr = ADDR_W'(VECTOR_ADDR);
        endcase
    end

    always_comb begin
        case (memory_write_src_select)
            WSRC_RD2:       dm_wdata = read_data2;
            WSRC_PC_NEXT:   dm_wdata = (r_state == ST_IDLE) ? pc_plus_one[31:16] : pc_plus_one[15:0];
            WSRC_INTERRUPT: begin
                case (r_state)
                    ST_IDLE:  dm_wdata = pc[31:16];
                    ST_WORD2: dm_wdata = pc[15:0];
                    default:  dm_wdata = {13'b0, flag_register};
                endcase
            end
            default:        dm_wdata = read_data1;
        endcase
    end

    always_comb begin
        stall        = 1'b0;
        dm_we        = 1'b0;
        dm_re        = 1'b0;
        w_sp_inc     = 1'b0;
        w_sp_dec     = 1'b0;
        w_low_word   = 1'b0;
        w_flags_word = 1'b0;
        case (r_state)
            ST_IDLE: begin
                stall        = (w_words != WORDS_1);
                w_low_word   = (w_words == WORDS_2);
                w_flags_word = (w_words == WORDS_3);
            end
            ST_WORD2: begin
                stall      = (w_words == WORDS_3);
                w_low_word = (w_words == WORDS_3);
            end
            default: ;
        endcase
        if (w_push) begin
            dm_we    = 1'b1;
            w_sp_dec = 1'b1;
        end else if (w_pop) begin
            dm_re    = 1'b1;
            w_sp_inc = 1'b1;
        end else if (!w_stack) begin
            dm_we = mem_write;
            dm_re = mem_read & ~mem_write;
        end
    end

    assign w_pc_pop_done = w_pop & ~stall & (w_words != WORDS_1);

    always_ff @(posedge clk) begin
        if (w_pop && w_flags_word)
            r_pop_flags <= dm_rdata[2:0];
        if (w_pop && w_low_word)
            r_pop_lo <= dm_rdata;
    end

    // MEM/WB boundary: real operation only on the final word, bubble while stalling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_reg_write               <= 1'b0;
            wb_reg_write_address       <= 3'b0;
            wb_sel_out                 <= 2'b0;
            wb_alu_result              <= 16'b0;
            wb_mem_data                <= 16'b0;
            wb_ldm_value               <= 16'b0;
            pc_from_memory             <= 32'b0;
            pc_from_memory_valid       <= 1'b0;
            conditions_from_memory_pop <= 3'b0;
        end else begin
            if (stall) begin
                wb_reg_write <= 1'b0;
            end else begin
                wb_reg_write         <= reg_write;
                wb_reg_write_address <= reg_write_address;
                wb_sel_out           <= wb_sel;
                wb_alu_result        <= alu_result;
                wb_mem_data          <= dm_rdata;
                wb_ldm_value         <= ldm_value;
            end
            pc_from_memory_valid <= w_pc_pop_done;
            if (w_pc_pop_done) begin
                pc_from_memory <= {dm_rdata, r_pop_lo};
                if (w_words == WORDS_3)
                    conditions_from_memory_pop <= r_pop_flags;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Randomised and directed bench for memory_stage against a word-level stack/memory model.
module tb_memory_stage;

    logic        clk;
    logic        reset;
    logic [15:0] alu_result, read_data1, read_data2, ldm_value;
    logic [31:0] pc, pc_plus_one;
    logic [2:0]  flag_register;
    logic        mem_read, mem_write, mem_push, mem_pop, reg_write;
    logic        pc_choose_interrupt, pc_choose_memory;
    logic [1:0]  memory_address_select, memory_write_src_select, wb_sel;
    logic [2:0]  reg_write_address;
    logic [11:0] dm_addr;
    logic [15:0] dm_wdata, dm_rdata;
    logic        dm_we, dm_re, stall;
    logic [31:0] pc_from_memory;
    logic        pc_from_memory_valid;
    logic [2:0]  conditions_from_memory_pop;
    logic        wb_reg_write;
    logic [2:0]  wb_reg_write_address;
    logic [1:0]  wb_sel_out;
    logic [15:0] wb_alu_result, wb_mem_data, wb_ldm_value;
    logic [11:0] sp_out;

    logic [15:0] mem [0:4095];
    logic        tb_we;
    logic [11:0] tb_addr;
    logic [15:0] tb_data;

    logic [15:0] ref_mem [0:4095];
    logic [11:0] ref_sp;
    logic [2:0]  ref_cond;
    int          n_assert;
    int          n_fail;

    memory_stage #(.ADDR_W(12), .SP_RESET(12'hFFF)) dut (
        .clk(clk), .reset(reset),
        .alu_result(alu_result), .read_data1(read_data1), .read_data2(read_data2),
        .ldm_value(ldm_value), .pc(pc), .pc_plus_one(pc_plus_one),
        .flag_register(flag_register),
        .mem_read(mem_read), .mem_write(mem_write), .mem_push(mem_push), .mem_pop(mem_pop),
        .reg_write(reg_write), .pc_choose_interrupt(pc_choose_interrupt),
        .pc_choose_memory(pc_choose_memory),
        .memory_address_select(memory_address_select),
        .memory_write_src_select(memory_write_src_select),
        .wb_sel(wb_sel), .reg_write_address(reg_write_address),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_re(dm_re),
        .dm_rdata(dm_rdata), .stall(stall),
        .pc_from_memory(pc_from_memory), .pc_from_memory_valid(pc_from_memory_valid),
        .conditions_from_memory_pop(conditions_from_memory_pop),
        .wb_reg_write(wb_reg_write), .wb_reg_write_address(wb_reg_write_address),
        .wb_sel_out(wb_sel_out), .wb_alu_result(wb_alu_result),
        .wb_mem_data(wb_mem_data), .wb_ldm_value(wb_ldm_value), .sp_out(sp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_rdata = mem[dm_addr];
    always @(posedge clk) begin
        if (dm_we)
            mem[dm_addr] <= dm_wdata;
        else if (tb_we)
            mem[tb_addr] <= tb_data;
    end

    task automatic set_idle();
        mem_read = 0; mem_write = 0; mem_push = 0; mem_pop = 0; reg_write = 0;
        pc_choose_interrupt = 0; pc_choose_memory = 0;
        memory_address_select = 2'b00; memory_write_src_select = 2'b00;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        ref_sp = 12'hFFF;
        ref_cond = 3'b000;
    endtask

    task automatic tb_write(input logic [11:0] a, input logic [15:0] d);
        tb_we = 1; tb_addr = a; tb_data = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        tb_we = 0;
    endtask

    // Runs the operation on the inputs until stall drops; counts cycles and stall cycles.
    task automatic run_op(output int n_cycles, output int n_stall);
        logic s;
        n_cycles = 0;
        n_stall = 0;
        forever begin
            #1;
            s = stall;
            n_assert++;
            if (dm_we && dm_re) begin
                n_fail++;
                $display("FAIL we_re_exclusive: dm_we=%b dm_re=%b required not both", dm_we, dm_re);
            end
            @(posedge clk); #1;
            n_cycles++;
            if (!s) break;
            n_stall++;
            n_assert++;
            if (wb_reg_write !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_bubble: wb_reg_write=%b required 0", wb_reg_write);
            end
            if (n_cycles > 6) begin
                n_fail++;
                $display("FAIL op_timeout: still stalled after %0d cycles, required <= 3", n_cycles);
                break;
            end
        end
        set_idle();
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        n_assert++; if (sp_out !== 12'hFFF) begin n_fail++; $display("FAIL rst_sp: got %h required %h", sp_out, 12'hFFF); end
        n_assert++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b required 0", stall); end
        n_assert++; if (pc_from_memory !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h required 0", pc_from_memory); end
        n_assert++; if (pc_from_memory_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", pc_from_memory_valid); end
        n_assert++; if (conditions_from_memory_pop !== 3'b0) begin n_fail++; $display("FAIL rst_cond: got %b required 0", conditions_from_memory_pop); end
        n_assert++; if ({wb_reg_write, wb_reg_write_address, wb_sel_out} !== 6'b0) begin n_fail++; $display("FAIL rst_wb_ctrl: got %b required 0", {wb_reg_write, wb_reg_write_address, wb_sel_out}); end
        n_assert++; if ({wb_alu_result, wb_mem_data, wb_ldm_value} !== 48'b0) begin n_fail++; $display("FAIL rst_wb_data: got %h required 0", {wb_alu_result, wb_mem_data, wb_ldm_value}); end
        reset = 0;
        ref_sp = 12'hFFF;
        ref_cond = 3'b000;
    endtask

    task automatic preload();
        for (int i = 0; i < 4096; i++) begin
            tb_write(12'(i), 16'($urandom));
        end
    endtask

    task automatic test_push_single();
        int nc, ns;
        do_reset();
        read_data2 = 16'h1234; mem_push = 1;
        memory_address_select = 2'b01; memory_write_src_select = 2'b00;
        run_op(nc, ns);
        ref_mem[12'hFFF] = 16'h1234; ref_sp = 12'hFFE;
        n_assert++; if (mem[12'hFFF] !== 16'h1234) begin n_fail++; $display("FAIL push1_mem: got %h required 1234", mem[12'hFFF]); end
        n_assert++; if (sp_out !== 12'hFFE) begin n_fail++; $display("FAIL push1_sp: got %h required ffe", sp_out); end
        n_assert++; if (ns !== 0) begin n_fail++; $display("FAIL push1_stall: got %0d stall cycles required 0", ns); end
    endtask

    task automatic test_call_push();
        int nc, ns;
        do_reset();
        pc_plus_one = 32'h0001_0020; reg_write = 1; mem_push = 1;
        memory_address_select = 2'b01; memory_write_src_select = 2'b01;
        run_op(nc, ns);
        ref_mem[12'hFFF] = 16'h0001; ref_mem[12'hFFE] = 16'h0020; ref_sp = 12'hFFD;
        n_assert++; if (mem[12'hFFF] !== 16'h0001) begin n_fail++; $display("FAIL call_hi: got %h required 0001", mem[12'hFFF]); end
        n_assert++; if (mem[12'hFFE] !== 16'h0020) begin n_fail++; $display("FAIL call_lo: got %h required 0020", mem[12'hFFE]); end
        n_assert++; if (sp_out !== 12'hFFD) begin n_fail++; $display("FAIL call_sp: got %h required ffd", sp_out); end
        n_assert++; if (ns !== 1) begin n_fail++; $display("FAIL call_stall: got %0d stall cycles required 1", ns); end
        n_assert++; if (wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL call_wb_final: got %b required 1", wb_reg_write); end
    endtask

    task automatic test_interrupt_rti();
        int nc, ns;
        do_reset();
        pc = 32'h0000_0100; flag_register = 3'b101; mem_push = 1;
        memory_address_select = 2'b01; memory_write_src_select = 2'b10;
        run_op(nc, ns);
        n_assert++; if (ns !== 2) begin n_fail++; $display("FAIL int_stall: got %0d stall cycles required 2", ns); end
        n_assert++; if (sp_out !== 12'hFFC) begin n_fail++; $display("FAIL int_sp: got %h required ffc", sp_out); end
        n_assert++; if (mem[12'hFFD] !== 16'h0005) begin n_fail++; $display("FAIL int_flags_mem: got %h required 0005", mem[12'hFFD]); end
        mem_pop = 1; pc_choose_interrupt = 1; pc_choose_memory = 1;
        memory_address_select = 2'b10;
        run_op(nc, ns);
        n_assert++; if (ns !== 2) begin n_fail++; $display("FAIL rti_stall: got %0d stall cycles required 2", ns); end
        n_assert++; if (pc_from_memory_valid !== 1'b1) begin n_fail++; $display("FAIL rti_valid: got %b required 1", pc_from_memory_valid); end
        n_assert++; if (pc_from_memory !== 32'h0000_0100) begin n_fail++; $display("FAIL rti_pc: got %h required 00000100", pc_from_memory); end
        n_assert++; if (conditions_from_memory_pop !== 3'b101) begin n_fail++; $display("FAIL rti_cond: got %b required 101", conditions_from_memory_pop); end
        n_assert++; if (sp_out !== 12'hFFF) begin n_fail++; $display("FAIL rti_sp: got %h required fff", sp_out); end
        @(posedge clk); #1;
        n_assert++; if (pc_from_memory_valid !== 1'b0) begin n_fail++; $display("FAIL rti_valid_pulse: got %b required 0", pc_from_memory_valid); end
        n_assert++; if (conditions_from_memory_pop !== 3'b101) begin n_fail++; $display("FAIL rti_cond_hold: got %b required 101", conditions_from_memory_pop); end
        ref_mem[12'hFFF] = 16'h0000; ref_mem[12'hFFE] = 16'h0100; ref_mem[12'hFFD] = 16'h0005;
        ref_sp = 12'hFFF; ref_cond = 3'b101;
    endtask

    task automatic test_sp_wrap();
        int nc, ns;
        logic [15:0] exp_w;
        do_reset();
        exp_w = ref_mem[12'h000];
        mem_pop = 1; memory_address_select = 2'b10;
        run_op(nc, ns);
        n_assert++; if (sp_out !== 12'h000) begin n_fail++; $display("FAIL wrap_pop_sp: got %h required 000", sp_out); end
        n_assert++; if (wb_mem_data !== exp_w) begin n_fail++; $display("FAIL wrap_pop_data: got %h required %h", wb_mem_data, exp_w); end
        read_data2 = 16'h5A5A; mem_push = 1;
        memory_address_select = 2'b01; memory_write_src_select = 2'b00;
        #1;
        n_assert++; if (dm_addr !== 12'h000) begin n_fail++; $display("FAIL wrap_push_addr: got %h required 000", dm_addr); end
        run_op(nc, ns);
        ref_mem[12'h000] = 16'h5A5A;
        n_assert++; if (mem[12'h000] !== 16'h5A5A) begin n_fail++; $display("FAIL wrap_push_mem: got %h required 5a5a", mem[12'h000]); end
        n_assert++; if (sp_out !== 12'hFFF) begin n_fail++; $display("FAIL wrap_push_sp: got %h required fff", sp_out); end
        mem_pop = 1; memory_address_select = 2'b10;
        run_op(nc, ns);
        n_assert++; if (wb_mem_data !== 16'h5A5A) begin n_fail++; $display("FAIL wrap_repop_data: got %h required 5a5a", wb_mem_data); end
        ref_sp = 12'h000;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        tb_write(12'hFFE, 16'hDEAD);
        pc_plus_one = 32'hABCD_1234; mem_push = 1;
        memory_address_select = 2'b01; memory_write_src_select = 2'b01;
        #1;
        @(posedge clk); #1;
        reset = 1;
        set_idle();
        @(posedge clk); #1;
        n_assert++; if (sp_out !== 12'hFFF) begin n_fail++; $display("FAIL midrst_sp: got %h required fff", sp_out); end
        n_assert++; if (stall !== 1'b0) begin n_fail++; $display("FAIL midrst_stall: got %b required 0", stall); end
        n_assert++; if ({pc_from_memory_valid, wb_reg_write, wb_mem_data} !== 18'b0) begin n_fail++; $display("FAIL midrst_outs: got %h required 0", {pc_from_memory_valid, wb_reg_write, wb_mem_data}); end
        reset = 0;
        @(posedge clk); #1;
        n_assert++; if (mem[12'hFFF] !== 16'hABCD) begin n_fail++; $display("FAIL midrst_partial: got %h required abcd", mem[12'hFFF]); end
        n_assert++; if (mem[12'hFFE] !== 16'hDEAD) begin n_fail++; $display("FAIL midrst_untouched: got %h required dead", mem[12'hFFE]); end
        n_assert++; if (sp_out !== 12'hFFF) begin n_fail++; $display("FAIL midrst_sp_idle: got %h required fff", sp_out); end
        ref_mem[12'hFFF] = 16'hABCD; ref_sp = 12'hFFF; ref_cond = 3'b000;
    endtask

    task automatic test_mem_access();
        int nc, ns;
        do_reset();
        tb_write(12'h055, 16'hBEEF);
        alu_result = 16'h0055; mem_read = 1; reg_write = 1; reg_write_address = 3'd5;
        wb_sel = 2'd1; ldm_value = 16'h7777;
        run_op(nc, ns);
        n_assert++; if (ns !== 0) begin n_fail++; $display("FAIL rd_stall: got %0d required 0", ns); end
        n_assert++; if (wb_mem_data !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data: got %h required beef", wb_mem_data); end
        n_assert++; if ({wb_reg_write, wb_reg_write_address, wb_sel_out} !== {1'b1, 3'd5, 2'd1}) begin n_fail++; $display("FAIL rd_wb_ctrl: got %b required 110101", {wb_reg_write, wb_reg_write_address, wb_sel_out}); end
        n_assert++; if ({wb_alu_result, wb_ldm_value} !== {16'h0055, 16'h7777}) begin n_fail++; $display("FAIL rd_wb_data: got %h required 00557777", {wb_alu_result, wb_ldm_value}); end
        alu_result = 16'h0123; read_data2 = 16'hC0DE; mem_read = 1; mem_write = 1;
        #1;
        n_assert++; if ({dm_we, dm_re} !== 2'b10) begin n_fail++; $display("FAIL rw_conflict: got we,re=%b required 10", {dm_we, dm_re}); end
        n_assert++; if (dm_addr !== 12'h123) begin n_fail++; $display("FAIL rw_addr: got %h required 123", dm_addr); end
        run_op(nc, ns);
        ref_mem[12'h123] = 16'hC0DE;
        n_assert++; if (mem[12'h123] !== 16'hC0DE) begin n_fail++; $display("FAIL wr_mem: got %h required c0de", mem[12'h123]); end
        mem_push = 1; mem_pop = 1; memory_address_select = 2'b01; memory_write_src_select = 2'b01;
        #1;
        n_assert++; if ({dm_we, dm_re, stall} !== 3'b000) begin n_fail++; $display("FAIL nop_ctrl: got we,re,stall=%b required 000", {dm_we, dm_re, stall}); end
        run_op(nc, ns);
        n_assert++; if (sp_out !== 12'hFFF) begin n_fail++; $display("FAIL nop_sp: got %h required fff", sp_out); end
        mem_read = 1; memory_address_select = 2'b11; alu_result = 16'h0FFF;
        #1;
        n_assert++; if (dm_addr !== 12'h000) begin n_fail++; $display("FAIL vector_addr: got %h required 000", dm_addr); end
        run_op(nc, ns);
    endtask

    task automatic test_random();
        logic [15:0] words[$];
        logic [11:0] addrs[$];
        logic [15:0] popped[$];
        int          op, nw, nc, ns;
        logic [1:0]  src;
        logic [31:0] exp_pc;
        logic        exp_rw, exp_valid;
        logic [15:0] exp_alu, exp_ldm;
        for (int k = 0; k < 120; k++) begin
            words.delete(); addrs.delete(); popped.delete();
            alu_result = 16'($urandom); read_data1 = 16'($urandom); read_data2 = 16'($urandom);
            ldm_value = 16'($urandom); pc = $urandom; pc_plus_one = $urandom;
            flag_register = 3'($urandom); reg_write = 1'($urandom);
            reg_write_address = 3'($urandom); wb_sel = 2'($urandom);
            exp_rw = reg_write; exp_alu = alu_result; exp_ldm = ldm_value;
            exp_pc = 32'h0;
            op = $urandom_range(0, 7);
            nw = 1;
            case (op)
                0: begin
                    src = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
                    mem_push = 1; memory_address_select = 2'b01; memory_write_src_select = src;
                    words.push_back(src == 2'b00 ? read_data2 : read_data1);
                end
                1: begin
                    mem_push = 1; memory_address_select = 2'b01; memory_write_src_select = 2'b01;
                    words.push_back(pc_plus_one[31:16]); words.push_back(pc_plus_one[15:0]);
                end
                2: begin
                    mem_push = 1; memory_address_select = 2'b01; memory_write_src_select = 2'b10;
                    words.push_back(pc[31:16]); words.push_back(pc[15:0]);
                    words.push_back({13'b0, flag_register});
                end
                3: begin mem_pop = 1; memory_address_select = 2'b10; nw = 1; end
                4: begin mem_pop = 1; memory_address_select = 2'b10; pc_choose_memory = 1; nw = 2; end
                5: begin
                    mem_pop = 1; memory_address_select = 2'b10;
                    pc_choose_memory = 1; pc_choose_interrupt = 1; nw = 3;
                end
                6: begin
                    mem_write = 1; memory_address_select = 2'b00; memory_write_src_select = 2'b00;
                    ref_mem[alu_result[11:0]] = read_data2;
                    addrs.push_back(alu_result[11:0]); words.push_back(read_data2);
                end
                default: begin
                    mem_read = 1; memory_address_select = 2'b00;
                    popped.push_back(ref_mem[alu_result[11:0]]);
                end
            endcase
            if (op <= 2) begin
                nw = words.size();
                foreach (words[i]) begin
                    addrs.push_back(ref_sp);
                    ref_mem[ref_sp] = words[i];
                    ref_sp = ref_sp - 12'd1;
                end
            end else if (op <= 5) begin
                for (int i = 0; i < nw; i++) begin
                    ref_sp = ref_sp + 12'd1;
                    popped.push_back(ref_mem[ref_sp]);
                end
                if (nw == 3) begin
                    ref_cond = popped[0][2:0];
                    exp_pc = {popped[2], popped[1]};
                end else if (nw == 2) begin
                    exp_pc = {popped[1], popped[0]};
                end
            end
            exp_valid = (op == 4 || op == 5);
            run_op(nc, ns);
            n_assert++; if (ns !== nw - 1) begin n_fail++; $display("FAIL rnd_stall op%0d: got %0d required %0d", op, ns, nw - 1); end
            n_assert++; if (sp_out !== ref_sp) begin n_fail++; $display("FAIL rnd_sp op%0d: got %h required %h", op, sp_out, ref_sp); end
            n_assert++; if (pc_from_memory_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid op%0d: got %b required %b", op, pc_from_memory_valid, exp_valid); end
            n_assert++; if (conditions_from_memory_pop !== ref_cond) begin n_fail++; $display("FAIL rnd_cond op%0d: got %b required %b", op, conditions_from_memory_pop, ref_cond); end
            n_assert++; if ({wb_reg_write, wb_alu_result, wb_ldm_value} !== {exp_rw, exp_alu, exp_ldm}) begin n_fail++; $display("FAIL rnd_wb op%0d: got %h required %h", op, {wb_reg_write, wb_alu_result, wb_ldm_value}, {exp_rw, exp_alu, exp_ldm}); end
            foreach (addrs[i]) begin
                n_assert++; if (mem[addrs[i]] !== words[i]) begin n_fail++; $display("FAIL rnd_mem op%0d @%h: got %h required %h", op, addrs[i], mem[addrs[i]], words[i]); end
            end
            if (exp_valid) begin
                n_assert++; if (pc_from_memory !== exp_pc) begin n_fail++; $display("FAIL rnd_pc op%0d: got %h required %h", op, pc_from_memory, exp_pc); end
            end
            if (op == 3 || op == 7) begin
                n_assert++; if (wb_mem_data !== popped[0]) begin n_fail++; $display("FAIL rnd_rdata op%0d: got %h required %h", op, wb_mem_data, popped[0]); end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert = 0; n_fail = 0;
        tb_we = 0; tb_addr = 12'h0; tb_data = 16'h0;
        alu_result = 0; read_data1 = 0; read_data2 = 0; ldm_value = 0;
        pc = 0; pc_plus_one = 0; flag_register = 0; wb_sel = 0; reg_write_address = 0;
        ref_sp = 12'hFFF; ref_cond = 3'b000;
        test_reset();
        preload();
        test_push_single();
        test_call_push();
        test_interrupt_rti();
        test_sp_wrap();
        test_reset_mid_op();
        test_mem_access();
        do_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter ADDR_W, default 12, data-memory word-address width.
REQ-002 Parameter SP_RESET, default all-ones of ADDR_W, stack-pointer reset value.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 alu_result, read_data1, read_data2, ldm_value  in  16 each  EX/MEM operands.
REQ-006 pc, pc_plus_one  in  32 each  EX/MEM program counters.
REQ-007 flag_register  in  3  {carry, negative, zero}.
REQ-008 mem_read, mem_write, mem_push, mem_pop, reg_write, pc_choose_interrupt, pc_choose_memory  in  1 each  EX/MEM controls.
REQ-009 memory_address_select, memory_write_src_select, wb_sel  in  2 each; reg_write_address  in  3.
REQ-010 dm_addr  out  ADDR_W; dm_wdata  out  16; dm_we, dm_re  out  1; dm_rdata  in  16, combinational read of dm_addr.
REQ-011 stall  out  1  upstream EX/MEM must hold while high.
REQ-012 pc_from_memory  out  32; pc_from_memory_valid  out  1; conditions_from_memory_pop  out  3.
REQ-013 wb_reg_write, wb_reg_write_address(3), wb_sel_out(2), wb_alu_result(16), wb_mem_data(16), wb_ldm_value(16)  out  MEM/WB register.
REQ-014 sp_out  out  ADDR_W  current stack pointer.

Function
REQ-015 Address select: 00 alu_result[ADDR_W-1:0]; 01 SP (push); 10 SP+1 (pop); 11 vector address 0.
REQ-016 Write-source select: 00 read_data2 (1 word); 01 pc_plus_one (2 words); 10 pc then flags (3 words, interrupt); 11 read_data1 (1 word).
REQ-017 FSM states IDLE, WORD2, WORD3; one word transferred per cycle.
REQ-018 Single-word push: dm_we=1 at SP, SP<=SP-1, stays IDLE, stall=0.
REQ-019 Two-word push: IDLE writes high half at SP; WORD2 writes low half at SP-1; SP decremented by 2 at WORD2 exit; stall=1 in IDLE cycle only.
REQ-020 Interrupt push (select 10): high PC, low PC, then {13'b0, flag_register} in WORD3; SP-=3; stall high for the first two cycles.
REQ-021 Pop is the mirror: pc_choose_interrupt=1 pops flags (SP+1), then PC low, then PC high; otherwise PC low then high; SP increments per word.
REQ-022 pc_from_memory_valid pulses exactly one cycle after the final pop word, with {high,low} assembled; conditions_from_memory_pop updates in the same cycle when flags were popped, otherwise holds.
REQ-023 Non-stack mem_read/mem_write: one cycle at the selected address, no SP change, no stall.
REQ-024 SP arithmetic wraps modulo 2^ADDR_W (push at 0 -> all-ones, pop at all-ones -> 0).
REQ-025 mem_read and mem_write both high: write wins, dm_re=0.
REQ-026 mem_push and mem_pop both high: treated as no-op, SP unchanged, no memory access.
REQ-027 MEM/WB register loads only on the final cycle of an operation; during stall cycles it loads a bubble (wb_reg_write=0).
REQ-028 wb_mem_data captures dm_rdata in the final read cycle.
REQ-029 dm_we, dm_re asserted only in cycles performing an access; never both high.

Reset
REQ-030 Reset mid-operation aborts the FSM to IDLE immediately; partial writes are not undone.
REQ-031 Reset values: SP=SP_RESET, state IDLE, stall=0, pc_from_memory=0, pc_from_memory_valid=0, conditions_from_memory_pop=0, all wb_* outputs 0.

Structure
REQ-032 Package memory_stage_pkg holds the FSM state enum, address-select and write-source encodings, and the vector address constant.
REQ-033 One sub-module stack_pointer (load, increment, decrement by 1 per word, wrap) is instantiated inside.

Verification
REQ-034 SP=0xFFF, push read_data2=0x1234 -> mem[0xFFF]=0x1234, SP=0xFFE, stall never high.
REQ-035 CALL push pc_plus_one=0x0001_0020 -> mem[0xFFF]=0x0001, mem[0xFFE]=0x0020, SP=0xFFD, stall high one cycle, one bubble on wb_reg_write.
REQ-036 Interrupt push pc=0x0000_0100, flags=3'b101, then RTI pop -> pc_from_memory=0x0000_0100 with one-cycle valid, conditions_from_memory_pop=3'b101, SP restored to 0xFFF.
REQ-037 SP=0x000, single push -> write at 0x000, SP=0xFFF; subsequent pop reads 0x000.
REQ-038 Assert reset in WORD2 of a two-word push -> state IDLE, SP=0xFFF, stall=0, all outputs at reset values next cycle.
REQ-039 mem_read with alu_result=0x0055, mem[0x055]=0xBEEF, reg_write=1 -> next cycle wb_mem_data=0xBEEF, wb_reg_write=1, no stall.
